// File: rtl/spi_cfg_master_pkg.sv
// Shared constants, FSM state encoding and frame helper for the SPI configuration master.
package spi_cfg_master_pkg;

    localparam int SPI_ADDR_W    = 7;
    localparam int SPI_DATA_W    = 8;
    localparam int SPI_FRAME_W   = 16;
    localparam int SPI_WRITE_BIT = 15;

    localparam logic [SPI_ADDR_W-1:0] REG_ADDR_0 = 7'd0;
    localparam logic [SPI_ADDR_W-1:0] REG_ADDR_1 = 7'd1;
    localparam logic [SPI_ADDR_W-1:0] REG_ADDR_2 = 7'd2;
    localparam logic [SPI_ADDR_W-1:0] REG_ADDR_3 = 7'd3;
    localparam logic [SPI_ADDR_W-1:0] REG_ADDR_4 = 7'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    function automatic logic [SPI_FRAME_W-1:0] build_frame(input logic [SPI_ADDR_W-1:0] addr,
                                                           input logic [SPI_DATA_W-1:0] data);
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_cfg_master_rr_arb.sv
// Round-robin arbiter: grants the first asserted request after the pointer position.
module spi_cfg_rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// Round-robin SPI mode-0 write master for the 5-register configuration peripheral.
// Optional write-suppressing shadow copy enabled by macro SPI_CFG_SHADOW_EN.
module spi_cfg_master
    import spi_cfg_master_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CLK_DIV  = 4,
    parameter int MAX_ADDR = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*SPI_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*SPI_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            sclk,
    output logic                            copi,
    output logic                            ncs,
    output logic                            busy,
    output logic                            done,
    output logic                            err
`ifdef SPI_CFG_SHADOW_EN
    ,
    output logic [(MAX_ADDR+1)*SPI_DATA_W-1:0] shadow_regs
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [SPI_ADDR_W-1:0] ADDR_LIMIT = SPI_ADDR_W'(MAX_ADDR);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       div_cnt, div_cnt_n;
    logic [4:0]             bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [NUM_REQ-1:0]     arb_req;
    logic [SPI_ADDR_W-1:0]  sel_addr;
    logic [SPI_DATA_W-1:0]  sel_data;
    logic [SPI_FRAME_W-1:0] frame, frame_load;
    logic                   addr_bad, shadow_hit;
    logic                   load, shift, done_n, err_n, active_n;

    // Requests are only visible to the arbiter while idle and out of reset.
    assign arb_req = (state == ST_IDLE && !rst) ? req_valid : '0;

    spi_cfg_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (arb_req),
        .ptr       (ptr),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_addr   = req_addr[grant_idx*SPI_ADDR_W +: SPI_ADDR_W];
    assign sel_data   = req_data[grant_idx*SPI_DATA_W +: SPI_DATA_W];
    assign addr_bad   = sel_addr > ADDR_LIMIT;
    assign frame_load = build_frame(sel_addr, sel_data);

`ifdef SPI_CFG_SHADOW_EN
    logic [(MAX_ADDR+1)*SPI_DATA_W-1:0] shadow_q;
    logic [SPI_ADDR_W-1:0]              addr_q;
    logic [SPI_DATA_W-1:0]              data_q;

    always_comb begin
        shadow_hit = 1'b0;
        for (int i = 0; i <= MAX_ADDR; i++) begin
            if (sel_addr == SPI_ADDR_W'(i) && shadow_q[i*SPI_DATA_W +: SPI_DATA_W] == sel_data)
                shadow_hit = 1'b1;
        end
    end

    // Entries commit only when a full frame has gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (done_n && state == ST_SHIFT_LO) begin
            for (int i = 0; i <= MAX_ADDR; i++) begin
                if (addr_q == SPI_ADDR_W'(i))
                    shadow_q[i*SPI_DATA_W +: SPI_DATA_W] <= data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            addr_q <= sel_addr;
            data_q <= sel_data;
        end
    end

    assign shadow_regs = shadow_q;
`else
    assign shadow_hit = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    if (addr_bad) begin
                        err_n = 1'b1;
                    end else if (shadow_hit) begin
                        done_n = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_n   = ST_SETUP;
                        div_cnt_n = '0;
                        bit_cnt_n = '0;
                    end
                end
            end
            ST_SETUP: begin
                if (div_cnt == HALF_LAST) begin
                    state_n   = ST_SHIFT_HI;
                    div_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_cnt == HALF_LAST) begin
                    state_n   = ST_SHIFT_LO;
                    div_cnt_n = '0;
                    shift     = 1'b1;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (div_cnt == HALF_LAST) begin
                    div_cnt_n = '0;
                    if (bit_cnt == 5'd15) begin
                        state_n = ST_GAP;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = ST_SHIFT_HI;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (div_cnt == GAP_LAST) begin
                    state_n   = ST_IDLE;
                    div_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign active_n = (state_n == ST_SETUP) || (state_n == ST_SHIFT_HI) || (state_n == ST_SHIFT_LO);

    // Control and pin registers; pins are decoded from the next state so they switch glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            ptr     <= IDX_W'(NUM_REQ - 1);
            ncs     <= 1'b1;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            done    <= done_n;
            err     <= err_n;
            ncs     <= !active_n;
            sclk    <= (state_n == ST_SHIFT_HI);
            busy    <= (state_n != ST_IDLE);
            if (grant_any)
                ptr <= grant_idx;
            if (load)
                copi <= frame_load[SPI_WRITE_BIT];
            else if (shift)
                copi <= frame[SPI_WRITE_BIT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (load)
            frame <= frame_load;
        else if (shift)
            frame <= {frame[SPI_FRAME_W-2:0], 1'b0};
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Self-checking bench for spi_cfg_master: vector table, hand sequences and a random phase vs a reference model.
module tb_spi_cfg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [13:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        sclk, copi, ncs, busy, done, err;

    logic        rst2 = 1'b1;
    logic [1:0]  v2 = '0;
    logic [13:0] a2 = '0;
    logic [15:0] d2 = '0;
    logic [1:0]  rdy2;
    logic        sclk2, copi2, ncs2, busy2, done2, err2;

`ifdef SPI_CFG_SHADOW_EN
    logic [39:0] shadow_regs, shadow2;
    localparam bit SHADOW_ON = 1'b1;
`else
    localparam bit SHADOW_ON = 1'b0;
`endif

    spi_cfg_master #(.NUM_REQ(2), .CLK_DIV(4), .MAX_ADDR(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .sclk(sclk), .copi(copi), .ncs(ncs), .busy(busy), .done(done), .err(err)
`ifdef SPI_CFG_SHADOW_EN
        , .shadow_regs(shadow_regs)
`endif
    );

    spi_cfg_master #(.NUM_REQ(2), .CLK_DIV(2), .MAX_ADDR(4)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(v2), .req_addr(a2), .req_data(d2),
        .req_ready(rdy2), .sclk(sclk2), .copi(copi2), .ncs(ncs2), .busy(busy2), .done(done2), .err(err2)
`ifdef SPI_CFG_SHADOW_EN
        , .shadow_regs(shadow2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: collects accepts, pulses and the bits seen on each sclk rising edge.
    int          acc_idx_q[$], acc_cyc_q[$];
    logic [15:0] fq[$];
    int          lq[$], bq[$];
    bit          dq[$];
    int          done_count = 0, err_count = 0, last_done_cyc = 0, last_err_cyc = 0;
    int          onehot_bad = 0, mode0_bad = 0;
    logic [15:0] sh = '0;
    int          nb = 0, ln = 0;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sh = '0; nb = 0; ln = 0;
            prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
        end else begin
            if (req_ready != 2'b00) begin
                acc_idx_q.push_back(req_ready[1] ? 1 : 0);
                acc_cyc_q.push_back(cyc);
                if (req_ready == 2'b11) onehot_bad++;
            end
            if (done) begin done_count++; last_done_cyc = cyc; end
            if (err)  begin err_count++;  last_err_cyc = cyc;  end
            if (copi != prev_copi && sclk) mode0_bad++;
            if (!ncs) begin
                ln++;
                if (sclk && !prev_sclk) begin sh = {sh[14:0], copi}; nb++; end
            end
            if (ncs && !prev_ncs) begin
                fq.push_back(sh); lq.push_back(ln); bq.push_back(nb); dq.push_back(done);
                sh = '0; nb = 0; ln = 0;
            end
            prev_ncs = ncs; prev_sclk = sclk; prev_copi = copi;
        end
    end

    // Reference model state: round-robin pointer and last committed value per register.
    int         mdl_ptr = 1;
    logic [7:0] mdl_shadow[5];

    task automatic mdl_reset();
        mdl_ptr = 1;
        for (int i = 0; i < 5; i++) mdl_shadow[i] = 8'h00;
    endtask

    task automatic wait_acc(input int n, output bit ok);
        int t = 0;
        while (acc_idx_q.size() < n && t < 2000) begin @(posedge clk); t++; end
        ok = (acc_idx_q.size() >= n);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < 3000) begin
            @(posedge clk); #1; t++;
            if (!busy) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_check(input string tag, input logic [1:0] mask, input logic [6:0] a0, input logic [6:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1, input int eg, input bit eerr,
                            input bit eframe, input logic [15:0] ef);
        int na, nd, ne, nf, ac;
        bit ok, ok2;
        logic [6:0] ga;
        na = acc_idx_q.size(); nd = done_count; ne = err_count; nf = fq.size();
        @(posedge clk); #1;
        req_addr = {a1, a0}; req_data = {d1, d0}; req_valid = mask;
        wait_acc(na + 1, ok);
        req_valid = 2'b00;
        chk({tag, "_accept_wait"}, ok, 1);
        if (!ok) return;
        ac = acc_cyc_q[na];
        chk({tag, "_grant"}, acc_idx_q[na], eg);
        wait_idle(ok2);
        chk({tag, "_idle_wait"}, ok2, 1);
        chk({tag, "_err_pulses"}, err_count - ne, eerr ? 1 : 0);
        if (eerr) chk({tag, "_err_timing"}, last_err_cyc, ac + 1);
        chk({tag, "_frames"}, fq.size() - nf, eframe ? 1 : 0);
        chk({tag, "_done_pulses"}, done_count - nd, eerr ? 0 : 1);
        if (eframe && fq.size() > nf) begin
            chk({tag, "_frame"}, fq[nf], ef);
            chk({tag, "_ncs_low"}, lq[nf], 132);
            chk({tag, "_bits"}, bq[nf], 16);
            chk({tag, "_done_at_ncs_rise"}, dq[nf], 1);
        end
        if (!eerr && !eframe) chk({tag, "_done_timing"}, last_done_cyc, ac + 1);
        mdl_ptr = eg;
        ga = (eg == 1) ? a1 : a0;
        if (!eerr) mdl_shadow[ga] = (eg == 1) ? d1 : d0;
    endtask

    task automatic run_model(input string tag, input logic [1:0] mask, input logic [6:0] a0, input logic [6:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1);
        int g = -1;
        logic [6:0] a;
        logic [7:0] d;
        bit bad, hit;
        for (int k = 1; k <= 2; k++) begin
            if (g < 0 && mask[(mdl_ptr + k) % 2]) g = (mdl_ptr + k) % 2;
        end
        a = (g == 1) ? a1 : a0;
        d = (g == 1) ? d1 : d0;
        bad = (a > 7'd4);
        hit = !bad && SHADOW_ON && (mdl_shadow[a[2:0]] == d);
        do_check(tag, mask, a0, a1, d0, d1, g, bad, !bad && !hit, {1'b1, a, d});
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [6:0]  a0, a1;
        logic [7:0]  d0, d1;
        int          eg;
        bit          eerr;
        bit          eframe;
        logic [15:0] ef;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int c0, c1, c2;
        int ndone, nerr, nfr, t;
        int ln2, nb2, nd2;
        logic [15:0] sh2;
        logic ps2;

        vecs[0] = '{2'b01, 7'd3,  7'd0, 8'hA5, 8'h00, 0, 1'b0, 1'b1, 16'h83A5};
        vecs[1] = '{2'b11, 7'd1,  7'd4, 8'h3C, 8'h5A, 1, 1'b0, 1'b1, 16'h845A};
        vecs[2] = '{2'b10, 7'd0,  7'd5, 8'h00, 8'h77, 1, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{2'b11, 7'd2,  7'd0, 8'hC3, 8'h11, 0, 1'b0, 1'b1, 16'h82C3};
        vecs[4] = '{2'b11, 7'd6,  7'd2, 8'h01, 8'hE7, 1, 1'b0, 1'b1, 16'h82E7};
        vecs[5] = '{2'b11, 7'h7F, 7'd0, 8'h00, 8'h22, 0, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{2'b01, 7'd0,  7'd0, 8'h3E, 8'h00, 0, 1'b0, 1'b1, 16'h803E};

        // Reset state, with both requesters already asserting.
        req_addr = {7'd1, 7'd3}; req_data = {8'h22, 8'h11}; req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", ncs, 1); chk("rst_sclk", sclk, 0); chk("rst_copi", copi, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;

        // Both valid from reset: grants 0,1,0 at minimum spacing; req0 data change while busy is ignored.
        wait_acc(1, ok);
        chk("rr_acc1_wait", ok, 1);
        req_data[7:0] = 8'h44;
        wait_acc(3, ok);
        req_valid = 2'b00;
        chk("rr_acc3_wait", ok, 1);
        wait_idle(ok);
        chk("rr_idle_wait", ok, 1);
        if (acc_idx_q.size() >= 3 && fq.size() >= 3) begin
            chk("rr_g0", acc_idx_q[0], 0); chk("rr_g1", acc_idx_q[1], 1); chk("rr_g2", acc_idx_q[2], 0);
            c0 = acc_cyc_q[0]; c1 = acc_cyc_q[1]; c2 = acc_cyc_q[2];
            chk("rr_spacing1", c1 - c0, 141); chk("rr_spacing2", c2 - c1, 141);
            chk("rr_frame0", fq[0], 16'h8311); chk("rr_frame1", fq[1], 16'h8122); chk("rr_frame2", fq[2], 16'h8344);
            chk("rr_len2", lq[2], 132);
        end

        // Fresh reset, then the vector table.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mdl_reset();
        for (int i = 0; i < 7; i++)
            do_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
                     vecs[i].eg, vecs[i].eerr, vecs[i].eframe, vecs[i].ef);

        // Reset in the 40th cycle of a frame.
        ndone = done_count; nerr = err_count;
        @(posedge clk); #1;
        req_addr = {7'd0, 7'd1}; req_data = {8'h00, 8'h5A}; req_valid = 2'b01;
        wait_acc(acc_idx_q.size() + 1, ok);
        req_valid = 2'b00;
        chk("midrst_accept_wait", ok, 1);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ncs", ncs, 1); chk("midrst_sclk", sclk, 0); chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        nfr = fq.size();
        repeat (200) @(posedge clk);
        #1;
        chk("midrst_no_done", done_count - ndone, 0);
        chk("midrst_no_err", err_count - nerr, 0);
        chk("midrst_quiet_bus", fq.size() - nfr, 0);
        mdl_reset();
        run_model("post_rst", 2'b11, 7'd1, 7'd3, 8'h96, 8'h69);

`ifdef SPI_CFG_SHADOW_EN
        run_model("shadow_first", 2'b01, 7'd2, 7'd0, 8'h10, 8'h00);
        chk("shadow_entry2", shadow_regs[23:16], 8'h10);
        run_model("shadow_repeat", 2'b01, 7'd2, 7'd0, 8'h10, 8'h00);
        chk("shadow_entry2_kept", shadow_regs[23:16], 8'h10);
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 10; i++)
            run_model($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)), 7'($urandom_range(0, 6)),
                      7'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));

        chk("grant_onehot", onehot_bad, 0);
        chk("copi_stable_while_sclk_high", mode0_bad, 0);

        // CLK_DIV=2 instance: addr 0, data 0xFF.
        @(posedge clk); #1 rst2 = 1'b0;
        a2 = '0; d2 = {8'h00, 8'hFF}; v2 = 2'b01;
        t = 0;
        while (rdy2 != 2'b01 && t < 100) begin @(negedge clk); t++; end
        chk("div2_ready", rdy2, 2'b01);
        @(posedge clk); #1 v2 = 2'b00;
        ln2 = 0; nb2 = 0; nd2 = 0; sh2 = '0; ps2 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!ncs2) begin
                ln2++;
                if (sclk2 && !ps2) begin sh2 = {sh2[14:0], copi2}; nb2++; end
            end
            ps2 = sclk2;
            if (done2) nd2++;
        end
        chk("div2_ncs_low", ln2, 66);
        chk("div2_frame", sh2, 16'h80FF);
        chk("div2_bits", nb2, 16);
        chk("div2_done", nd2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
